// File: rtl/train_phase_sched_pkg.sv
// train_phase_sched_pkg: phase encoding, scheduler states and default sizing shared with the engine side.
package train_phase_sched_pkg;
    localparam int DEF_MAX_LAYERS = 8;
    localparam int DEF_TIMEOUT = 255;
    typedef enum logic [1:0] {PH_IDLE = 2'b00, PH_FP = 2'b01, PH_BP = 2'b10, PH_WG = 2'b11} phase_t;
    typedef enum logic [3:0] {
        S_IDLE, S_FP_ISSUE, S_FP_WAIT, S_BP_ISSUE, S_BP_WAIT, S_WG_ISSUE, S_WG_WAIT, S_DONE, S_ERR
    } state_t;
endpackage

// File: rtl/train_phase_sched_if.sv
// train_phase_sched_if: control, engine command and status signals of the training phase scheduler.
interface train_phase_sched_if import train_phase_sched_pkg::*; #(parameter int MAX_LAYERS = DEF_MAX_LAYERS);
    logic start, abort, eng_done;
    logic [3:0] num_layers;
    logic [MAX_LAYERS-1:0] stride_cfg;
    logic eng_start;
    logic [1:0] eng_phase;
    logic [2:0] eng_layer;
    logic select0, select1, busy, iter_done, cfg_err, timeout_err;
    modport master(
        output start, abort, num_layers, stride_cfg, eng_done,
        input eng_start, eng_phase, eng_layer, select0, select1, busy, iter_done, cfg_err, timeout_err
    );
    modport slave(
        input start, abort, num_layers, stride_cfg, eng_done,
        output eng_start, eng_phase, eng_layer, select0, select1, busy, iter_done, cfg_err, timeout_err
    );
endinterface

// File: rtl/train_phase_sched_phase_watchdog.sv
// phase_watchdog: counts wait cycles since the last command issue; expired flags the final allowed cycle.
module phase_watchdog import train_phase_sched_pkg::*; #(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    logic [7:0] cnt;
    always_ff @(posedge clk)
        if (rst || clear) cnt <= '0;
        else if (tick) cnt <= cnt + 8'd1;
    // The move to ERR happens on the edge where the count would reach TIMEOUT.
    assign expired = cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/train_phase_sched.sv
// train_phase_sched: sequences FP over all layers, then BP/WG pairs in reverse, one engine command at a time.
module train_phase_sched import train_phase_sched_pkg::*; #(
    parameter int MAX_LAYERS = DEF_MAX_LAYERS,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic clk,
    input logic fsm_rst,
    train_phase_sched_if.slave bus
);
    localparam logic [3:0] MAX_N = 4'(MAX_LAYERS);
    state_t state, state_nx;
    logic [2:0] layer, layer_nx;
    logic [3:0] n_q;
    logic [MAX_LAYERS-1:0] stride_q;
    logic cfg_err_q, cfg_ok, idle_req, accept, issue, wait_st, expired, last_fp, s;
    phase_t ph;
    assign cfg_ok = bus.num_layers != 4'd0 && bus.num_layers <= MAX_N;
    assign idle_req = state == S_IDLE && bus.start && !bus.abort;
    assign accept = idle_req && cfg_ok;
    assign issue = state inside {S_FP_ISSUE, S_BP_ISSUE, S_WG_ISSUE};
    assign wait_st = state inside {S_FP_WAIT, S_BP_WAIT, S_WG_WAIT};
    assign last_fp = layer == 3'(n_q - 4'd1);
    phase_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk(clk), .rst(fsm_rst), .clear(issue), .tick(wait_st && !bus.eng_done), .expired(expired)
    );
    always_comb begin
        state_nx = state;
        layer_nx = layer;
        case (state)
            S_IDLE:     if (accept) begin state_nx = S_FP_ISSUE; layer_nx = '0; end
            S_FP_ISSUE: state_nx = S_FP_WAIT;
            S_BP_ISSUE: state_nx = S_BP_WAIT;
            S_WG_ISSUE: state_nx = S_WG_WAIT;
            S_FP_WAIT:
                if (bus.eng_done) begin
                    state_nx = last_fp ? S_BP_ISSUE : S_FP_ISSUE;
                    layer_nx = last_fp ? layer : layer + 3'd1;
                end else if (expired) state_nx = S_ERR;
            S_BP_WAIT:
                if (bus.eng_done) state_nx = S_WG_ISSUE;
                else if (expired) state_nx = S_ERR;
            S_WG_WAIT:
                if (bus.eng_done) begin
                    state_nx = layer == 3'd0 ? S_DONE : S_BP_ISSUE;
                    layer_nx = layer == 3'd0 ? layer : layer - 3'd1;
                end else if (expired) state_nx = S_ERR;
            S_DONE:     state_nx = S_IDLE;
            S_ERR:      state_nx = S_ERR;
            default:    state_nx = S_IDLE;
        endcase
        if (bus.abort) begin
            state_nx = S_IDLE;
            layer_nx = '0;
        end
    end
    always_ff @(posedge clk)
        if (fsm_rst) begin
            state <= S_IDLE;
            layer <= '0;
            n_q <= '0;
            stride_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state <= state_nx;
            layer <= layer_nx;
            cfg_err_q <= idle_req && !cfg_ok;
            if (accept) begin
                n_q <= bus.num_layers;
                stride_q <= bus.stride_cfg;
            end
        end
    assign ph = state inside {S_FP_ISSUE, S_FP_WAIT} ? PH_FP :
                state inside {S_BP_ISSUE, S_BP_WAIT} ? PH_BP :
                state inside {S_WG_ISSUE, S_WG_WAIT} ? PH_WG : PH_IDLE;
    assign s = ph != PH_IDLE && stride_q[layer];
    assign bus.eng_start = issue;
    assign bus.eng_phase = ph;
    assign bus.eng_layer = ph != PH_IDLE ? layer : 3'd0;
    assign bus.select0 = s && ph != PH_BP;
    assign bus.select1 = s;
    assign bus.busy = state != S_IDLE;
    assign bus.iter_done = state == S_DONE;
    assign bus.cfg_err = cfg_err_q;
    assign bus.timeout_err = state == S_ERR;
endmodule

// File: tb/tb_train_phase_sched.sv
// tb_train_phase_sched: randomized iterations checked against a command-list model built from the scheduling rules.
module tb_train_phase_sched;
    import train_phase_sched_pkg::*;
    localparam int ML = 8;
    localparam int TMO = 20;
    logic clk = 1'b0;
    logic fsm_rst = 1'b1;
    int checks = 0, failures = 0, cyc = 0;
    logic [11:0] outs;
    train_phase_sched_if #(.MAX_LAYERS(ML)) bus();
    train_phase_sched #(.MAX_LAYERS(ML), .TIMEOUT(TMO)) dut (.clk(clk), .fsm_rst(fsm_rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign outs = {bus.eng_start, bus.eng_phase, bus.eng_layer, bus.select0, bus.select1,
                   bus.busy, bus.iter_done, bus.cfg_err, bus.timeout_err};

    // Expected command list: FP 0..N-1, then BP/WG pairs from N-1 down to 0; engine answers after d wait cycles.
    task automatic run_iteration(input int n, input logic [ML-1:0] stride, input int dfix, input int stop_at, input bit hold);
        int ph_q[$], ly_q[$];
        int total, c0, d;
        logic [6:0] exp;
        logic sb;
        for (int i = 0; i < n; i++) begin ph_q.push_back(1); ly_q.push_back(i); end
        for (int i = n - 1; i >= 0; i--) begin
            ph_q.push_back(2); ly_q.push_back(i);
            ph_q.push_back(3); ly_q.push_back(i);
        end
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_layers = 4'(n); bus.stride_cfg = stride;
        c0 = cyc; total = 2;
        @(posedge clk); #1;
        bus.start = hold;
        if (!hold) begin bus.num_layers = 4'($urandom); bus.stride_cfg = ML'($urandom); end
        for (int k = 0; k < ph_q.size(); k++) begin
            sb = stride[ly_q[k]];
            exp = {2'(ph_q[k]), 3'(ly_q[k]), sb && ph_q[k] != 2, sb};
            @(negedge clk);
            checks++;
            if ({bus.eng_start, bus.busy, bus.eng_phase, bus.eng_layer, bus.select0, bus.select1} !== {2'b11, exp}) begin
                failures++;
                $display("FAIL issue cmd=%0d got start,busy,ph,ly,s0,s1=%b expected %b", k,
                         {bus.eng_start, bus.busy, bus.eng_phase, bus.eng_layer, bus.select0, bus.select1}, {2'b11, exp});
            end
            if (k == stop_at) return;
            d = dfix >= 0 ? dfix : ($urandom_range(0, 7) == 0 ? TMO - 1 : int'($urandom_range(0, 3)));
            total += 2 + d;
            @(posedge clk); #1;
            for (int w = 0; w < d; w++) begin
                if (!hold) bus.start = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if ({bus.eng_start, bus.busy, bus.timeout_err, bus.eng_phase, bus.eng_layer, bus.select0, bus.select1} !== {3'b010, exp}) begin
                    failures++;
                    $display("FAIL wait cmd=%0d cyc=%0d got %b expected %b", k, w,
                             {bus.eng_start, bus.busy, bus.timeout_err, bus.eng_phase, bus.eng_layer, bus.select0, bus.select1}, {3'b010, exp});
                end
                @(posedge clk); #1;
            end
            bus.start = hold; bus.eng_done = 1'b1;
            @(posedge clk); #1;
            bus.eng_done = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({bus.iter_done, bus.busy, bus.eng_start} !== 3'b110) begin
            failures++;
            $display("FAIL done_pulse got iter_done,busy,eng_start=%b expected 110", {bus.iter_done, bus.busy, bus.eng_start});
        end
        checks++;
        if (cyc - c0 + 1 != total) begin
            failures++;
            $display("FAIL latency n=%0d got %0d cycles expected %0d", n, cyc - c0 + 1, total);
        end
        @(negedge clk);
        checks++;
        if ({bus.iter_done, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL back_to_idle got iter_done,busy=%b expected 00", {bus.iter_done, bus.busy});
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.abort = 0; bus.eng_done = 0; bus.num_layers = 0; bus.stride_cfg = 0;
        fsm_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs !== 12'd0) begin failures++; $display("FAIL reset_outputs got %b expected 0", outs); end
        @(posedge clk); #1 fsm_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 12'd0) begin failures++; $display("FAIL after_reset got %b expected 0", outs); end
    endtask

    task automatic test_example();
        run_iteration(2, 8'b0000_0010, 2, -1, 1'b0);
    endtask

    task automatic test_cfg_reject();
        int vals[3] = '{0, 9, 15};
        foreach (vals[i]) begin
            @(posedge clk); #1 bus.start = 1'b1; bus.num_layers = 4'(vals[i]);
            @(posedge clk); #1 bus.start = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus.cfg_err, bus.busy, bus.eng_start} !== 3'b100) begin
                failures++;
                $display("FAIL cfg_reject n=%0d got cfg_err,busy,eng_start=%b expected 100", vals[i], {bus.cfg_err, bus.busy, bus.eng_start});
            end
            @(negedge clk);
            checks++;
            if ({bus.cfg_err, bus.busy, bus.eng_start} !== 3'b000) begin
                failures++;
                $display("FAIL cfg_pulse n=%0d got cfg_err,busy,eng_start=%b expected 000", vals[i], {bus.cfg_err, bus.busy, bus.eng_start});
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) run_iteration(int'($urandom_range(1, ML)), ML'($urandom), -1, -1, 1'b0);
        run_iteration(ML, ML'($urandom), 0, -1, 1'b0);
    endtask

    task automatic test_timeout();
        @(posedge clk); #1 bus.start = 1'b1; bus.num_layers = 4'd1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk);
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.timeout_err, bus.busy} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_early got timeout_err,busy=%b expected 01", {bus.timeout_err, bus.busy});
        end
        @(negedge clk);
        checks++;
        if ({bus.timeout_err, bus.busy, bus.eng_start, bus.eng_phase} !== 5'b11000) begin
            failures++;
            $display("FAIL timeout_rise got timeout_err,busy,start,phase=%b expected 11000", {bus.timeout_err, bus.busy, bus.eng_start, bus.eng_phase});
        end
        @(posedge clk); #1 bus.eng_done = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1 bus.eng_done = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL err_hold got %b expected 1", bus.timeout_err); end
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.timeout_err, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL err_abort got timeout_err,busy=%b expected 00", {bus.timeout_err, bus.busy});
        end
    endtask

    task automatic test_done_at_expiry();
        run_iteration(2, ML'($urandom), TMO - 1, -1, 1'b0);
    endtask

    task automatic test_abort_mid();
        run_iteration(3, ML'($urandom), 1, 1, 1'b0);
        @(posedge clk); #1 bus.abort = 1'b1; bus.eng_done = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0; bus.eng_done = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 12'd0) begin failures++; $display("FAIL abort_mid got %b expected 0", outs); end
        run_iteration(3, ML'($urandom), -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_iteration(4, ML'($urandom), 1, 4, 1'b0);
        @(posedge clk); #1 fsm_rst = 1'b1;
        @(posedge clk); #1 fsm_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.eng_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (outs !== 12'd0) begin failures++; $display("FAIL reset_mid cyc=%0d got %b expected 0", i, outs); end
            @(posedge clk); #1;
        end
        bus.eng_done = 1'b0;
        run_iteration(4, ML'($urandom), -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_iteration(1, 8'b0000_0001, 0, -1, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.eng_start, bus.busy, bus.eng_phase, bus.eng_layer} !== 7'b1101000) begin
            failures++;
            $display("FAIL back_to_back got start,busy,ph,ly=%b expected 1101000", {bus.eng_start, bus.busy, bus.eng_phase, bus.eng_layer});
        end
        @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_abort got busy=%b expected 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_example();
        test_cfg_reject();
        test_random();
        test_timeout();
        test_done_at_expiry();
        test_abort_mid();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
